// File: rtl/bcd_disp_if.sv
// Capture-side and display-side signals of the 4-digit multiplexed BCD display.
interface bcd_disp_if;
  logic       load;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic       carry;
  logic [3:0] an;
  logic [7:0] sseg;

  modport master (
    output load, digit0, digit1, digit2, carry,
    input  an, sseg
  );

  modport slave (
    input  load, digit0, digit1, digit2, carry,
    output an, sseg
  );
endinterface

// File: rtl/bcd_disp_mux.sv
// Time-multiplexed 4-position seven-segment driver for a 3-digit BCD value plus carry,
// with optional leading-zero blanking and registered an/sseg.
module bcd_disp_mux #(
  parameter int unsigned N        = 18,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  bcd_disp_if.slave  bus
);

  logic [N-1:0] q;
  logic [3:0]   h0, h1, h2;
  logic         h3;

  logic [1:0]   sel_c;
  logic [3:0]   cur_c;
  logic         blank_c;
  logic [6:0]   seg_c;
  logic [3:0]   an_c;
  logic [7:0]   sseg_c;

  // Refresh counter, value capture and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      h0       <= 4'h0;
      h1       <= 4'h0;
      h2       <= 4'h0;
      h3       <= 1'b0;
      bus.an   <= 4'b1111;
      bus.sseg <= 8'hFF;
    end else begin
      q        <= q + N'(1);
      if (bus.load) begin
        h0 <= bus.digit0;
        h1 <= bus.digit1;
        h2 <= bus.digit2;
        h3 <= bus.carry;
      end
      bus.an   <= an_c;
      bus.sseg <= sseg_c;
    end
  end

  // Position select, leading-zero blanking and segment decode from pre-edge state.
  always_comb begin
    sel_c   = q[N-1:N-2];
    cur_c   = 4'h0;
    blank_c = 1'b0;
    seg_c   = 7'b1111110;
    an_c    = 4'b1111;
    sseg_c  = 8'hFF;

    unique case (sel_c)
      2'd0: cur_c = h0;
      2'd1: cur_c = h1;
      2'd2: cur_c = h2;
      2'd3: cur_c = {3'b000, h3};
    endcase

    // A dash (non-BCD) digit is nonzero, so it stops blanking like any other digit.
    unique case (sel_c)
      2'd3:    blank_c = ~h3;
      2'd2:    blank_c = ~h3 && (h2 == 4'h0);
      2'd1:    blank_c = ~h3 && (h2 == 4'h0) && (h1 == 4'h0);
      default: blank_c = 1'b0;
    endcase
    blank_c = blank_c && BLANK_LZ;

    case (cur_c)
      4'd0:    seg_c = 7'b0000001;
      4'd1:    seg_c = 7'b1001111;
      4'd2:    seg_c = 7'b0010010;
      4'd3:    seg_c = 7'b0000110;
      4'd4:    seg_c = 7'b1001100;
      4'd5:    seg_c = 7'b0100100;
      4'd6:    seg_c = 7'b0100000;
      4'd7:    seg_c = 7'b0001111;
      4'd8:    seg_c = 7'b0000000;
      4'd9:    seg_c = 7'b0000100;
      default: seg_c = 7'b1111110;
    endcase

    if (!blank_c) begin
      an_c[sel_c] = 1'b0;
      sseg_c      = {1'b1, seg_c};
    end
  end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Bench for bcd_disp_mux: blanking and non-blanking instances share one stimulus stream,
// checked every cycle against a display model built from digit values and scan position.
module tb_bcd_disp_mux;
  localparam int unsigned N     = 4;
  localparam int unsigned DWELL = 2 ** (N - 2);
  localparam int unsigned SPAN  = 2 ** N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_disp_if bus_lz();
  bcd_disp_if bus_nb();

  assign bus_nb.load   = bus_lz.load;
  assign bus_nb.digit0 = bus_lz.digit0;
  assign bus_nb.digit1 = bus_lz.digit1;
  assign bus_nb.digit2 = bus_lz.digit2;
  assign bus_nb.carry  = bus_lz.carry;

  bcd_disp_mux #(.N(N), .BLANK_LZ(1'b1)) dut_lz (.clk(clk), .reset(reset), .bus(bus_lz));
  bcd_disp_mux #(.N(N), .BLANK_LZ(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cnt   = 0;
  logic [3:0]  hv [4];
  logic [3:0]  exp_an_lz, exp_an_nb;
  logic [7:0]  exp_sseg_lz, exp_sseg_nb;
  bit          exp_valid = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  // What the display should show for the current counter and held digits.
  task automatic render(input bit blz, output logic [3:0] an, output logic [7:0] sseg);
    int pos  = int'((cnt / DWELL) % 4);
    int lead = 0;
    for (int i = 1; i < 4; i++)
      if (hv[i] != 4'h0) lead = i;
    if (blz && pos > lead) begin
      an   = 4'b1111;
      sseg = 8'hFF;
    end else begin
      an   = ~(4'(1) << pos);
      sseg = {1'b1, seg_of(hv[pos])};
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input bit c);
    @(negedge clk);
    if (exp_valid) begin
      check("an_lz",   {4'h0, bus_lz.an}, {4'h0, exp_an_lz});
      check("sseg_lz", bus_lz.sseg,       exp_sseg_lz);
      check("an_nb",   {4'h0, bus_nb.an}, {4'h0, exp_an_nb});
      check("sseg_nb", bus_nb.sseg,       exp_sseg_nb);
    end
    reset         = rst;
    bus_lz.load   = ld;
    bus_lz.digit0 = d0;
    bus_lz.digit1 = d1;
    bus_lz.digit2 = d2;
    bus_lz.carry  = c;
    if (rst) begin
      exp_an_lz = 4'b1111; exp_sseg_lz = 8'hFF;
      exp_an_nb = 4'b1111; exp_sseg_nb = 8'hFF;
      cnt = 0;
      for (int i = 0; i < 4; i++) hv[i] = 4'h0;
    end else begin
      render(1'b1, exp_an_lz, exp_sseg_lz);
      render(1'b0, exp_an_nb, exp_sseg_nb);
      cnt = (cnt + 1) % SPAN;
      if (ld) begin
        hv[0] = d0; hv[1] = d1; hv[2] = d2; hv[3] = {3'b000, c};
      end
    end
    exp_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(1) == 0) return 4'h0;
    return 4'($urandom_range(15));
  endfunction

  initial begin
    reset         = 1'b1;
    bus_lz.load   = 1'b0;
    bus_lz.digit0 = 4'h0;
    bus_lz.digit1 = 4'h0;
    bus_lz.digit2 = 4'h0;
    bus_lz.carry  = 1'b0;
    for (int i = 0; i < 4; i++) hv[i] = 4'h0;

    // Reset, then a full idle scan showing a lone "0".
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    idle(34);

    step(1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 1'b0);  // "999"
    idle(18);
    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);  // "1000"
    idle(18);
    step(1'b0, 1'b1, 4'd5, 4'd0, 4'd2, 1'b0);  // "205"
    idle(18);
    step(1'b0, 1'b1, 4'h3, 4'hC, 4'h0, 1'b0);  // dash in tens
    idle(18);

    // Load held high, recapturing each cycle.
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, rnd_digit(), rnd_digit(), rnd_digit(), 1'($urandom_range(1)));

    // Reset and load together while position 2 is on screen.
    step(1'b0, 1'b1, 4'd7, 4'd6, 4'd5, 1'b1);
    for (int i = 0; i < 16 && ((cnt / DWELL) % 4) != 2; i++)
      step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1);
    idle(18);

    // Random traffic with occasional loads and resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(7) == 0,
           rnd_digit(), rnd_digit(), rnd_digit(), 1'($urandom_range(1)));
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_disp_mux.md
BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

Interface
REQ-001 Parameter N, default 18: refresh counter width; each digit position is displayed for 2^(N-2) clk cycles; legal range N >= 3.
REQ-002 Parameter BLANK_LZ, default 1: 1 = leading-zero blanking enabled, 0 = disabled.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  capture strobe; samples digit0..2 and carry when high at a clk edge.
REQ-006 digit0, digit1, digit2  input  4 each  BCD ones/tens/hundreds from the 3-digit incrementor outputs.
REQ-007 carry  input  1  thousands digit; 1 = displays "1", 0 = displays "0".
REQ-008 an  output  4  digit enables, active-low, one bit per position (an[0] = ones ... an[3] = thousands).
REQ-009 sseg  output  8  segments, active-low: sseg[7] = dp, sseg[6:0] = a,b,c,d,e,f,g.

Function
REQ-010 The block SHALL hold four value registers h0,h1,h2 (4 bits each) and h3 (1 bit), loaded from digit0,digit1,digit2,carry on any clk edge where load=1 and reset=0.
REQ-011 Display content SHALL come only from the value registers; values loaded at edge k SHALL first appear in an/sseg at edge k+1.
REQ-012 A free-running N-bit refresh counter q SHALL increment by 1 every clk and wrap from 2^N-1 to 0; it is independent of load.
REQ-013 Position sel = q[N-1:N-2]: 0 -> h0, 1 -> h1, 2 -> h2, 3 -> {3'b000,h3}.
REQ-014 an and sseg SHALL be registered; their value after edge k reflects sel and the value registers as they were before edge k (one-cycle latency).
REQ-015 For an unblanked position, an SHALL be low only at bit sel, all other bits high.
REQ-016 Segment codes sseg[6:0]: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-017 Non-BCD value (4'hA-4'hF) SHALL display dash: sseg[6:0]=1111110; a dash counts as nonzero for blanking.
REQ-018 sseg[7] (dp) SHALL always be 1 (off).
REQ-019 With BLANK_LZ=1: position 3 blanked iff h3=0; position 2 blanked iff h3=0 and h2=0; position 1 blanked iff h3=0, h2=0 and h1=0; position 0 never blanked.
REQ-020 A blanked position SHALL drive an=4'b1111 and sseg=8'hFF.
REQ-021 With BLANK_LZ=0 no position is ever blanked.
REQ-022 load held high continuously SHALL re-capture every cycle; no other side effect.

Reset
REQ-023 reset=1 at an edge SHALL clear q, h0..h3 to 0 and drive an=4'b1111, sseg=8'hFF after that edge; reset has priority over load.
REQ-024 Reset asserted mid-scan SHALL take effect at the next edge regardless of sel or load; the scan SHALL restart at sel=0 after release.
REQ-025 After reset release without load, the display SHALL show "0" at position 0 (an=1110, sseg=8'b10000001) and positions 1-3 blanked (BLANK_LZ=1).

Verification (benches use N=4: 4 cycles per position)
REQ-026 Reset 2 cycles, no load -> an=1111/sseg=FF right after reset; then position 0: an=1110, sseg=10000001; positions 1-3: an=1111, sseg=11111111; pattern repeats every 16 cycles.
REQ-027 load once with 9,9,9, carry=0 -> positions 0-2 show sseg=10000100 with an=1110/1101/1011; position 3 blanked.
REQ-028 load with 0,0,0, carry=1 ("1000") -> all four lit; position 3: an=0111, sseg=11001111; positions 0-2: sseg=10000001.
REQ-029 load with 5,0,2, carry=0 ("205") -> position 1 shows 10000001 (not blanked), position 2 shows 10010010, position 3 blanked; with BLANK_LZ=0 position 3 shows an=0111, sseg=10000001.
REQ-030 load with digit1=4'hC, digit0=4'h3, others 0, carry=0 -> position 1: an=1101, sseg=11111110; position 0: sseg=10000110; positions 2-3 blanked.
REQ-031 reset and load both high at one edge during position 2 -> after edge an=1111, sseg=FF, h registers 0; after release, scan restarts at position 0 showing "0".
